// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader: state encoding and default widths.
package imem_loader_pkg;

  localparam int unsigned AW_DEF = 4;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Core fetch port plus byte-serial loader handshake, bundled for the instruction memory.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic [AW-1:0] Addr;
  logic          En;
  logic          RW;
  logic [DW-1:0] WData;
  logic [DW-1:0] Data;
  logic          LdValid;
  logic [7:0]    LdByte;
  logic          LdLast;
  logic          LdReady;
  logic          Reload;
  logic          ProgReady;
  logic [AW:0]   WordCnt;

  modport master (
    output Addr, En, RW, WData, LdValid, LdByte, LdLast, Reload,
    input  Data, LdReady, ProgReady, WordCnt
  );

  modport slave (
    input  Addr, En, RW, WData, LdValid, LdByte, LdLast, Reload,
    output Data, LdReady, ProgReady, WordCnt
  );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs loader bytes MSB-first into a word; a last byte flushes early with low bytes zeroed.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          accept,
  input  logic [7:0]    byte_in,
  input  logic          last,
  output logic          word_done_c,
  output logic [DW-1:0] word_c
);

  localparam int unsigned BPW = bytes_per_word(DW);
  localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] asm_q, asm_d;
  int unsigned   shamt;

  // Lower byte lanes of asm_q are always zero, so OR-ing in the new byte also zero-pads.
  always_comb begin
    shamt       = 8 * (BPW - 1 - 32'(cnt_q));
    word_c      = asm_q | (DW'(byte_in) << shamt);
    word_done_c = accept && (last || (cnt_q == CW'(BPW - 1)));
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    if (clear || word_done_c) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (accept) begin
      cnt_d = CW'(cnt_q + 1'b1);
      asm_d = word_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory for the GPP core: byte-serial program load, then one-cycle registered fetch.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  imem_loader_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** AW;

  state_e        state_q, state_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [DW-1:0] data_q, data_d;

  logic          ld_accept_c;
  logic          reload_c;
  logic          word_done_c;
  logic [DW-1:0] word_c;

  // LdReady is decoded from state, so acceptance is simply valid while loading.
  assign ld_accept_c = bus.LdValid && (state_q == S_LOAD);
  assign reload_c    = bus.Reload && (state_q == S_RUN);

  imem_loader_byte_assembler #(.DW(DW)) u_asm (
    .clk         (Clk),
    .rst         (Rst),
    .clear       (reload_c),
    .accept      (ld_accept_c),
    .byte_in     (bus.LdByte),
    .last        (bus.LdLast),
    .word_done_c (word_done_c),
    .word_c      (word_c)
  );

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    if (state_q == S_LOAD) begin
      if (word_done_c) begin
        mem_d[ptr_q] = word_c;
        ptr_d        = AW'(ptr_q + 1'b1);
        wcnt_d       = (AW+1)'(wcnt_q + 1'b1);
        // Leave on the last byte, or when this write fills the memory.
        if (bus.LdLast || (wcnt_q == (AW+1)'(DEPTH - 1))) begin
          state_d = S_RUN;
        end
      end
    end else begin
      if (bus.En) begin
        if (bus.RW) begin
          mem_d[bus.Addr] = bus.WData;
        end else begin
          data_d = mem_q[bus.Addr];
        end
      end
      if (bus.Reload) begin
        state_d = S_LOAD;
        ptr_d   = '0;
        wcnt_d  = '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_LOAD;
      mem_q   <= '{default: '0};
      ptr_q   <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
    end
  end

  assign bus.Data      = data_q;
  assign bus.LdReady   = (state_q == S_LOAD);
  assign bus.ProgReady = (state_q == S_RUN);
  assign bus.WordCnt   = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: reads push expected words, a monitor pops and compares Data.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.AW(4), .DW(32)) bus ();
  imem_loader #(.AW(4), .DW(32)) dut (.Clk(clk), .Rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [16];
  int          model_wc;
  bit          model_run;
  logic [31:0] model_data;
  logic [31:0] exp_q [$];
  bit          rd_issue = 1'b0;
  bit          rd_pend  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a read issued in cycle N is compared on the negedge after its edge.
  always @(posedge clk) rd_pend <= rd_issue;
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_data: got %0h expected nothing (scoreboard empty)", bus.Data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("read_data", 64'(bus.Data), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    foreach (model_mem[i]) model_mem[i] = '0;
    model_wc   = 0;
    model_run  = 1'b0;
    model_data = '0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_wordcnt"}, 64'(bus.WordCnt), 64'(model_wc));
    check({tag, "_progready"}, 64'(bus.ProgReady), 64'(model_run));
    check({tag, "_ldready"}, 64'(bus.LdReady), 64'(!model_run));
    check({tag, "_data"}, 64'(bus.Data), 64'(model_data));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n = 0;
    while (bus.LdReady !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("ld_ready_timeout", 64'(bus.LdReady), 64'(1));
    bus.LdValid = 1'b1;
    bus.LdByte  = b;
    bus.LdLast  = last;
    tick();
    bus.LdValid = 1'b0;
    bus.LdLast  = 1'b0;
  endtask

  // Reference: byte i lands in word i/4, lane i%4 counted from the MSB; untouched lanes stay 0.
  task automatic load_program(input logic [7:0] bytes [$], input bit last, input bit stalls);
    logic [31:0] words [16];
    int n, nw;
    n = (bytes.size() > 64) ? 64 : bytes.size();
    foreach (words[w]) words[w] = '0;
    for (int i = 0; i < n; i++) words[i/4] |= 32'(bytes[i]) << (24 - 8 * (i % 4));
    for (int i = 0; i < n; i++) begin
      if (stalls && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      send_byte(bytes[i], last && (i == n - 1));
    end
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) model_mem[w] = words[w];
    model_wc  = nw;
    model_run = last || (n == 64);
  endtask

  task automatic core_read(input logic [3:0] a);
    bus.En   = 1'b1;
    bus.RW   = 1'b0;
    bus.Addr = a;
    if (model_run) begin
      exp_q.push_back(model_mem[a]);
      model_data = model_mem[a];
      rd_issue   = 1'b1;
    end
    tick();
    bus.En   = 1'b0;
    rd_issue = 1'b0;
  endtask

  task automatic core_write(input logic [3:0] a, input logic [31:0] d);
    bus.En    = 1'b1;
    bus.RW    = 1'b1;
    bus.Addr  = a;
    bus.WData = d;
    if (model_run) model_mem[a] = d;
    tick();
    bus.En = 1'b0;
    bus.RW = 1'b0;
  endtask

  task automatic do_reload(input bit with_byte, input bit with_read, input logic [3:0] a);
    bus.Reload = 1'b1;
    if (with_byte) begin
      bus.LdValid = 1'b1;
      bus.LdByte  = 8'hEE;
    end
    if (with_read) begin
      bus.En   = 1'b1;
      bus.RW   = 1'b0;
      bus.Addr = a;
      if (model_run) begin
        exp_q.push_back(model_mem[a]);
        model_data = model_mem[a];
        rd_issue   = 1'b1;
      end
    end
    tick();
    bus.Reload  = 1'b0;
    bus.LdValid = 1'b0;
    bus.En      = 1'b0;
    rd_issue    = 1'b0;
    if (model_run) begin
      model_wc  = 0;
      model_run = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [7:0] prog [$];
    rst = 1'b1;
    bus.Addr = '0; bus.En = 1'b0; bus.RW = 1'b0; bus.WData = '0;
    bus.LdValid = 1'b0; bus.LdByte = '0; bus.LdLast = 1'b0; bus.Reload = 1'b0;
    model_clear();
    repeat (2) tick();
    rst = 1'b0;
    check_status("reset");

    // Directed program load and read protocol
    prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07, 8'h00, 8'h22, 8'h18, 8'h20};
    load_program(prog, 1'b1, 1'b0);
    check_status("prog12");
    core_read(4'd0);
    core_read(4'd2);
    core_read(4'd1);
    repeat (2) tick();
    check_status("read_hold");

    // Early last: two bytes make one zero-padded word
    do_reload(1'b0, 1'b0, 4'd0);
    check_status("reload_a");
    prog = '{8'hAB, 8'hCD};
    load_program(prog, 1'b1, 1'b0);
    check_status("early_last");
    core_read(4'd0);
    core_read(4'd1);

    // Fill without last, then an extra byte that must be refused
    do_reload(1'b0, 1'b0, 4'd0);
    prog.delete();
    for (int i = 0; i < 64; i++) prog.push_back(8'($urandom));
    load_program(prog, 1'b0, 1'b1);
    check_status("fill");
    bus.LdValid = 1'b1;
    bus.LdByte  = 8'hFF;
    tick();
    bus.LdValid = 1'b0;
    check_status("fill_extra");
    core_read(4'd0);
    core_read(4'd15);

    // Reload with a same-cycle byte (refused) and read (served), then a 1-word program
    do_reload(1'b1, 1'b1, 4'd3);
    prog = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_program(prog, 1'b1, 1'b0);
    check_status("reload_b");
    core_read(4'd0);
    core_read(4'd1);

    // Randomized run traffic interleaved with reloads and fresh programs
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 20; k++) begin
        case ($urandom_range(0, 2))
          0: core_read(4'($urandom));
          1: core_write(4'($urandom), $urandom);
          default: tick();
        endcase
      end
      do_reload(1'($urandom), 1'($urandom), 4'($urandom));
      core_write(4'($urandom), $urandom);
      core_read(4'($urandom));
      begin
        int n;
        n = $urandom_range(1, 64);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
        load_program(prog, (n < 64) ? 1'b1 : 1'($urandom), 1'b1);
      end
      check_status("rand");
    end

    // Reset in the middle of a load discards everything
    do_reload(1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 1'b0);
    do_reset();
    check_status("mid_reset");
    prog = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_program(prog, 1'b1, 1'b0);
    core_read(4'd5);
    tick();
    check_status("post_reset");

    repeat (2) tick();
    check("scoreboard_drain", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
